// File: rtl/ika87ad_busbridge_pkg.sv
// rtl/ika87ad_busbridge_pkg.sv - shared FSM states, region map and address decode for the bus bridge
package ika87ad_busbridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM,
    ST_REQ,
    ST_HOLD,
    ST_WAITREL
  } state_e;

  typedef enum logic [1:0] {
    RG_ROM,
    RG_RAM,
    RG_IO,
    RG_NONE
  } region_e;

  localparam logic [15:0] ROM_BASE  = 16'h0000;
  localparam logic [15:0] ROM_LIMIT = 16'h0FFF;
  localparam logic [15:0] RAM_BASE  = 16'hFF00;
  localparam logic [15:0] RAM_LIMIT = 16'hFFFF;
  localparam logic [15:0] IO_ADDR   = 16'h1401;
  localparam int unsigned RAM_DEPTH = 256;

  // Offset compares keep the range checks free of always-true bounds.
  function automatic region_e decode_region(input logic [15:0] addr);
    region_e rg;
    if ((addr - ROM_BASE) <= (ROM_LIMIT - ROM_BASE)) begin
      rg = RG_ROM;
    end else if ((addr - RAM_BASE) <= (RAM_LIMIT - RAM_BASE)) begin
      rg = RG_RAM;
    end else if (addr == IO_ADDR) begin
      rg = RG_IO;
    end else begin
      rg = RG_NONE;
    end
    return rg;
  endfunction

endpackage

// File: rtl/ika87ad_busbridge_ram.sv
// rtl/ika87ad_busbridge_ram.sv - internal 256x8 RAM, synchronous write, registered read
module ika87ad_busbridge_ram
  import ika87ad_busbridge_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [RAM_DEPTH];
  logic [7:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ika87ad_busbridge.sv
// rtl/ika87ad_busbridge.sv - CPU strobe bridge to internal RAM and an ack-based external memory bus
module ika87ad_busbridge
  import ika87ad_busbridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [7:0]  OPENBUS = 8'hFF
) (
  input  logic        i_EMUCLK,
  input  logic        i_RESET,
  input  logic [15:0] i_A,
  input  logic        i_RD_n,
  input  logic        i_WR_n,
  input  logic [7:0]  i_DO,
  output logic [7:0]  o_DI,
  output logic        o_MEM_REQ,
  output logic        o_MEM_WE,
  output logic [15:0] o_MEM_ADDR,
  output logic [7:0]  o_MEM_WDATA,
  input  logic        i_MEM_ACK,
  input  logic [7:0]  i_MEM_RDATA,
  output logic        o_TIMEOUT,
  output logic        o_LATE
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  di_q, di_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic        timeout_q, timeout_d;
  logic        late_q, late_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;

  logic        start, is_write, released, ram_we;
  logic [7:0]  ram_addr, ram_rdata;
  region_e     region;

  assign start    = (rd_prev_q & ~rd_q) | (wr_prev_q & ~wr_q);
  assign is_write = ~wr_q;
  assign released = we_q ? wr_q : rd_q;
  assign region   = decode_region(i_A);
  assign cnt_inc  = cnt_q + 4'd1;
  // Read address goes to the RAM while still in IDLE so data is ready on RAM entry.
  assign ram_addr = (state_q == ST_IDLE) ? i_A[7:0] : addr_q[7:0];

  always_comb begin
    state_d   = state_q;
    rd_d      = i_RD_n;
    wr_d      = i_WR_n;
    rd_prev_d = rd_q;
    wr_prev_d = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    di_d      = di_q;
    we_d      = we_q;
    req_d     = req_q;
    timeout_d = timeout_q;
    late_d    = late_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = i_A;
          wdata_d = i_DO;
          we_d    = is_write;
          cnt_d   = '0;
          unique case (region)
            RG_RAM: state_d = ST_RAM;
            RG_ROM: begin
              if (is_write) begin
                state_d = ST_WAITREL;
              end else begin
                state_d = ST_REQ;
                req_d   = 1'b1;
              end
            end
            RG_IO: begin
              state_d = ST_REQ;
              req_d   = 1'b1;
            end
            default: begin
              state_d = ST_WAITREL;
              if (!is_write) begin
                di_d = OPENBUS;
              end
            end
          endcase
        end
      end
      ST_RAM: begin
        if (we_q) begin
          ram_we = ~i_RESET;
        end else begin
          di_d = ram_rdata;
        end
        state_d = ST_WAITREL;
      end
      ST_REQ: begin
        if (i_MEM_ACK) begin
          req_d = 1'b0;
          if (!we_q) begin
            di_d = i_MEM_RDATA;
          end
          if (released) begin
            late_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            req_d     = 1'b0;
            timeout_d = 1'b1;
            if (!we_q) begin
              di_d = OPENBUS;
            end
            state_d = ST_WAITREL;
          end
        end
      end
      ST_HOLD: state_d = ST_WAITREL;
      ST_WAITREL: begin
        if (rd_q && wr_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RESET) begin
      state_q   <= ST_IDLE;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      rd_prev_q <= 1'b1;
      wr_prev_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      di_q      <= OPENBUS;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      late_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rd_prev_q <= rd_prev_d;
      wr_prev_q <= wr_prev_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      di_q      <= di_d;
      we_q      <= we_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
      late_q    <= late_d;
      cnt_q     <= cnt_d;
    end
  end

  ika87ad_busbridge_ram u_ram (
    .clk   (i_EMUCLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign o_DI        = di_q;
  assign o_MEM_REQ   = req_q;
  assign o_MEM_WE    = we_q;
  assign o_MEM_ADDR  = addr_q;
  assign o_MEM_WDATA = wdata_q;
  assign o_TIMEOUT   = timeout_q;
  assign o_LATE      = late_q;

endmodule

// File: tb/tb_ika87ad_busbridge.sv
// tb/tb_ika87ad_busbridge.sv - directed self-checking bench for ika87ad_busbridge
module tb_ika87ad_busbridge;
  import ika87ad_busbridge_pkg::*;

  logic        clk = 1'b0;
  logic        i_RESET = 1'b1;
  logic [15:0] i_A = '0;
  logic        i_RD_n = 1'b1;
  logic        i_WR_n = 1'b1;
  logic [7:0]  i_DO = '0;
  logic [7:0]  o_DI;
  logic        o_MEM_REQ;
  logic        o_MEM_WE;
  logic [15:0] o_MEM_ADDR;
  logic [7:0]  o_MEM_WDATA;
  logic        i_MEM_ACK = 1'b0;
  logic [7:0]  i_MEM_RDATA = '0;
  logic        o_TIMEOUT;
  logic        o_LATE;

  int n_cmp = 0;
  int n_err = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_MEM_REQ === 1'b1) req_cycles++;
  end

  ika87ad_busbridge #(.TIMEOUT(15), .OPENBUS(8'hFF)) dut (
    .i_EMUCLK    (clk),
    .i_RESET     (i_RESET),
    .i_A         (i_A),
    .i_RD_n      (i_RD_n),
    .i_WR_n      (i_WR_n),
    .i_DO        (i_DO),
    .o_DI        (o_DI),
    .o_MEM_REQ   (o_MEM_REQ),
    .o_MEM_WE    (o_MEM_WE),
    .o_MEM_ADDR  (o_MEM_ADDR),
    .o_MEM_WDATA (o_MEM_WDATA),
    .i_MEM_ACK   (i_MEM_ACK),
    .i_MEM_RDATA (i_MEM_RDATA),
    .o_TIMEOUT   (o_TIMEOUT),
    .o_LATE      (o_LATE)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_access(input logic [15:0] a, input logic rd_n, input logic wr_n,
                              input logic [7:0] d);
    @(negedge clk);
    i_A    = a;
    i_DO   = d;
    i_RD_n = rd_n;
    i_WR_n = wr_n;
  endtask

  task automatic release_bus();
    i_RD_n = 1'b1;
    i_WR_n = 1'b1;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_MEM_REQ === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_req: o_MEM_REQ=%b after 10 cycles, required 1", o_MEM_REQ);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dut.state_q == ST_IDLE) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s idle: state=%0d, required IDLE", name, dut.state_q);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++; if (o_MEM_REQ !== 1'b0) begin n_err++; $display("FAIL reset req: got %b want 0", o_MEM_REQ); end
    n_cmp++; if (o_MEM_WE !== 1'b0) begin n_err++; $display("FAIL reset we: got %b want 0", o_MEM_WE); end
    n_cmp++; if (o_MEM_ADDR !== 16'h0000) begin n_err++; $display("FAIL reset addr: got %h want 0000", o_MEM_ADDR); end
    n_cmp++; if (o_MEM_WDATA !== 8'h00) begin n_err++; $display("FAIL reset wdata: got %h want 00", o_MEM_WDATA); end
    n_cmp++; if (o_DI !== 8'hFF) begin n_err++; $display("FAIL reset di: got %h want FF", o_DI); end
    n_cmp++; if (o_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL reset timeout: got %b want 0", o_TIMEOUT); end
    n_cmp++; if (o_LATE !== 1'b0) begin n_err++; $display("FAIL reset late: got %b want 0", o_LATE); end
    i_RESET = 1'b0;
    tick();
  endtask

  task automatic test_rom_read();
    bit found;
    int hi;
    hi = 0;
    start_access(16'h0010, 1'b0, 1'b1, 8'h00);
    wait_req(found);
    if (found) begin
      n_cmp++; if (o_MEM_ADDR !== 16'h0010) begin n_err++; $display("FAIL rom_read addr: got %h want 0010", o_MEM_ADDR); end
      n_cmp++; if (o_MEM_WE !== 1'b0) begin n_err++; $display("FAIL rom_read we: got %b want 0", o_MEM_WE); end
      for (int i = 0; i < 3; i++) begin
        if (o_MEM_REQ === 1'b1) hi++;
        if (i < 2) tick();
      end
      i_MEM_ACK   = 1'b1;
      i_MEM_RDATA = 8'h3A;
      tick();
      i_MEM_ACK   = 1'b0;
      i_MEM_RDATA = 8'h00;
      n_cmp++; if (hi != 3) begin n_err++; $display("FAIL rom_read req_cycles: got %0d want 3", hi); end
      n_cmp++; if (o_MEM_REQ !== 1'b0) begin n_err++; $display("FAIL rom_read req_hold: got %b want 0", o_MEM_REQ); end
      n_cmp++; if (o_DI !== 8'h3A) begin n_err++; $display("FAIL rom_read di: got %h want 3A", o_DI); end
    end
    tick();
    release_bus();
    wait_idle("rom_read");
    n_cmp++; if (o_LATE !== 1'b0) begin n_err++; $display("FAIL rom_read late: got %b want 0", o_LATE); end
  endtask

  task automatic test_timeout();
    bit found;
    int hi;
    hi = 0;
    start_access(16'h1401, 1'b0, 1'b1, 8'h00);
    wait_req(found);
    if (found) begin
      n_cmp++; if (o_MEM_ADDR !== 16'h1401) begin n_err++; $display("FAIL timeout addr: got %h want 1401", o_MEM_ADDR); end
      for (int i = 0; i < 40; i++) begin
        if (o_MEM_REQ !== 1'b1) break;
        hi++;
        tick();
      end
      n_cmp++; if (hi != 15) begin n_err++; $display("FAIL timeout req_cycles: got %0d want 15", hi); end
      n_cmp++; if (o_TIMEOUT !== 1'b1) begin n_err++; $display("FAIL timeout flag: got %b want 1", o_TIMEOUT); end
      n_cmp++; if (o_DI !== 8'hFF) begin n_err++; $display("FAIL timeout di: got %h want FF", o_DI); end
    end
    release_bus();
    wait_idle("timeout");
  endtask

  task automatic ram_write(input logic [15:0] a, input logic [7:0] d);
    start_access(a, 1'b1, 1'b0, d);
    repeat (3) tick();
    release_bus();
    wait_idle("ram_write");
  endtask

  task automatic test_ram();
    int base;
    logic [15:0] addrs [3];
    logic [7:0]  datas [3];
    addrs = '{16'hFF20, 16'hFF00, 16'hFFFF};
    datas = '{8'h55, 8'hA1, 8'h5E};
    base = req_cycles;
    for (int i = 0; i < 3; i++) ram_write(addrs[i], datas[i]);
    for (int i = 0; i < 3; i++) begin
      start_access(addrs[i], 1'b0, 1'b1, 8'h00);
      repeat (3) tick();
      n_cmp++;
      if (o_DI !== datas[i]) begin
        n_err++;
        $display("FAIL ram_read %h: got %h want %h", addrs[i], o_DI, datas[i]);
      end
      release_bus();
      wait_idle("ram_read");
    end
    n_cmp++; if (req_cycles != base) begin n_err++; $display("FAIL ram no_req: got %0d req cycles want 0", req_cycles - base); end
  endtask

  task automatic test_unmapped();
    int base;
    base = req_cycles;
    start_access(16'h2000, 1'b0, 1'b1, 8'h00);
    tick();
    n_cmp++; if (o_DI !== 8'h5E) begin n_err++; $display("FAIL unmapped di_before: got %h want 5E", o_DI); end
    tick();
    n_cmp++; if (o_DI !== 8'hFF) begin n_err++; $display("FAIL unmapped di: got %h want FF", o_DI); end
    release_bus();
    wait_idle("unmapped");
    n_cmp++; if (req_cycles != base) begin n_err++; $display("FAIL unmapped no_req: got %0d want 0", req_cycles - base); end
  endtask

  task automatic test_rom_write();
    int base;
    base = req_cycles;
    start_access(16'h0100, 1'b1, 1'b0, 8'h99);
    repeat (4) tick();
    n_cmp++; if (dut.state_q != ST_WAITREL) begin n_err++; $display("FAIL rom_write state: got %0d want WAITREL", dut.state_q); end
    release_bus();
    wait_idle("rom_write");
    n_cmp++; if (req_cycles != base) begin n_err++; $display("FAIL rom_write no_req: got %0d want 0", req_cycles - base); end
  endtask

  task automatic test_decode_boundaries();
    logic [15:0] addrs [6];
    logic        exp_req [6];
    logic [7:0]  rdat [6];
    addrs   = '{16'h0FFF, 16'h1000, 16'h0800, 16'hFEFF, 16'h1401, 16'h1400};
    exp_req = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rdat    = '{8'hA5, 8'h00, 8'h3C, 8'h00, 8'h7E, 8'h00};
    for (int i = 0; i < 6; i++) begin
      start_access(addrs[i], 1'b0, 1'b1, 8'h00);
      repeat (3) tick();
      n_cmp++;
      if (o_MEM_REQ !== exp_req[i]) begin
        n_err++;
        $display("FAIL decode %h req: got %b want %b", addrs[i], o_MEM_REQ, exp_req[i]);
      end
      if (exp_req[i]) begin
        i_MEM_ACK   = 1'b1;
        i_MEM_RDATA = rdat[i];
        tick();
        i_MEM_ACK   = 1'b0;
        n_cmp++;
        if (o_DI !== rdat[i]) begin n_err++; $display("FAIL decode %h di: got %h want %h", addrs[i], o_DI, rdat[i]); end
      end else begin
        n_cmp++;
        if (o_DI !== 8'hFF) begin n_err++; $display("FAIL decode %h di: got %h want FF", addrs[i], o_DI); end
      end
      release_bus();
      wait_idle("decode");
    end
  endtask

  task automatic test_late();
    bit found;
    start_access(16'h0000, 1'b0, 1'b1, 8'h00);
    wait_req(found);
    release_bus();
    if (found) begin
      repeat (2) tick();
      n_cmp++; if (o_MEM_REQ !== 1'b1) begin n_err++; $display("FAIL late req_continues: got %b want 1", o_MEM_REQ); end
      i_MEM_ACK   = 1'b1;
      i_MEM_RDATA = 8'hC3;
      tick();
      i_MEM_ACK   = 1'b0;
      n_cmp++; if (o_LATE !== 1'b1) begin n_err++; $display("FAIL late flag: got %b want 1", o_LATE); end
      n_cmp++; if (o_DI !== 8'hC3) begin n_err++; $display("FAIL late di: got %h want C3", o_DI); end
      n_cmp++; if (dut.state_q != ST_IDLE) begin n_err++; $display("FAIL late state: got %0d want IDLE", dut.state_q); end
    end
    i_RESET = 1'b1;
    tick();
    i_RESET = 1'b0;
    n_cmp++; if (o_LATE !== 1'b0) begin n_err++; $display("FAIL late_reset late: got %b want 0", o_LATE); end
    n_cmp++; if (o_DI !== 8'hFF) begin n_err++; $display("FAIL late_reset di: got %h want FF", o_DI); end
    n_cmp++; if (o_TIMEOUT !== 1'b0) begin n_err++; $display("FAIL late_reset timeout: got %b want 0", o_TIMEOUT); end
  endtask

  task automatic test_reset_midaccess();
    bit found;
    start_access(16'h1401, 1'b0, 1'b1, 8'h00);
    wait_req(found);
    i_RESET = 1'b1;
    release_bus();
    tick();
    i_RESET = 1'b0;
    n_cmp++; if (o_MEM_REQ !== 1'b0) begin n_err++; $display("FAIL midreset req: got %b want 0", o_MEM_REQ); end
    n_cmp++; if (dut.state_q != ST_IDLE) begin n_err++; $display("FAIL midreset state: got %0d want IDLE", dut.state_q); end
    tick();
  endtask

  task automatic test_ram_persist();
    start_access(16'hFF20, 1'b0, 1'b1, 8'h00);
    repeat (3) tick();
    n_cmp++; if (o_DI !== 8'h55) begin n_err++; $display("FAIL ram_persist di: got %h want 55", o_DI); end
    release_bus();
    wait_idle("ram_persist");
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_timeout();
    test_ram();
    test_unmapped();
    test_rom_write();
    test_decode_boundaries();
    test_late();
    test_reset_midaccess();
    test_ram_persist();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
